// File: rtl/gpio_mon_pkg.sv
// GPIO input monitor shared types and constants.
// Debounce width default, event FSM states, event codes.
package gpio_mon_pkg;

  localparam int DEB_W_DEF = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_e;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for an asynchronous pad input.
// Both flops clear to 0 on reset.
module gpio_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // shift the pad level through two flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/gpio_input_monitor.sv
// Debounced GPIO input with edge event capture.
// Single pending event slot with sticky overrun flag.
module gpio_input_monitor
  import gpio_mon_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             core_clk,
  input  logic             resetn,
  input  logic             gpio_in,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic             irq_en_rise,
  input  logic             irq_en_fall,
  output logic             gpio_level,
  output logic             evt_valid,
  output logic             evt_rise,
  input  logic             evt_ack,
  output logic             evt_overrun
);

  logic             w_sync_in;
  logic             w_diff;
  logic             w_load;
  logic             w_qe;
  logic [DEB_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_q;

  evt_state_e       r_state;
  evt_state_e       w_state_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_ovr;
  logic             w_ovr_nxt;

  gpio_sync2 u_sync (
    .i_clk   (core_clk),
    .i_rst_n (resetn),
    .i_d     (gpio_in),
    .o_q     (w_sync_in)
  );

  assign w_diff = (w_sync_in != r_level);
  assign w_load = w_diff && (r_cnt >= deb_limit);

  // debounce: count stable differing cycles, accept at the limit
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_diff) begin
      r_cnt   <= '0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_level <= w_sync_in;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // previous level, used to spot a level change one cycle later
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) r_level_q <= 1'b0;
    else         r_level_q <= r_level;
  end

  assign w_qe = (r_level ^ r_level_q) &&
                (r_level ? irq_en_rise : irq_en_fall);

  // event FSM state and payload registers
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rise  <= EVT_FALL;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rise  <= w_rise_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // event FSM next state: capture, ack, reload or overrun
  always_comb begin
    w_state_nxt = r_state;
    w_rise_nxt  = r_rise;
    w_ovr_nxt   = r_ovr;
    unique case (r_state)
      IDLE: begin
        if (w_qe) begin
          w_state_nxt = PENDING;
          w_rise_nxt  = r_level;
        end
      end
      PENDING: begin
        if (evt_ack) begin
          w_ovr_nxt = 1'b0;
          if (w_qe) w_rise_nxt  = r_level;
          else      w_state_nxt = IDLE;
        end else if (w_qe) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign gpio_level  = r_level;
  assign evt_valid   = (r_state == PENDING);
  assign evt_rise    = r_rise;
  assign evt_overrun = r_ovr;

endmodule

// File: tb/tb_gpio_input_monitor.sv
// Bench for gpio_input_monitor: directed cases plus
// random traffic against a behavioural model.
module tb_gpio_input_monitor;

  localparam int DW = 8;

  logic          core_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          gpio_in = 1'b0;
  logic [DW-1:0] deb_limit = '0;
  logic          irq_en_rise = 1'b0;
  logic          irq_en_fall = 1'b0;
  logic          evt_ack = 1'b0;
  logic          gpio_level;
  logic          evt_valid;
  logic          evt_rise;
  logic          evt_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_input_monitor #(.DEB_W(DW)) dut (
    .core_clk    (core_clk),
    .resetn      (resetn),
    .gpio_in     (gpio_in),
    .deb_limit   (deb_limit),
    .irq_en_rise (irq_en_rise),
    .irq_en_fall (irq_en_fall),
    .gpio_level  (gpio_level),
    .evt_valid   (evt_valid),
    .evt_rise    (evt_rise),
    .evt_ack     (evt_ack),
    .evt_overrun (evt_overrun)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    gpio_in = 1'b0;
    evt_ack = 1'b0;
    irq_en_rise = 1'b0;
    irq_en_fall = 1'b0;
    deb_limit = '0;
    tick(3);
    chk("rst_level", gpio_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_rise", evt_rise, 0);
    chk("rst_ovr", evt_overrun, 0);
    resetn = 1'b1;
    tick(1);
  endtask

  // behavioural model
  bit hist[$];
  bit m_lvl, m_prev, m_pend, m_rise, m_ovr;
  int m_run;

  task automatic model_reset();
    hist = {1'b0, 1'b0};
    m_lvl = 0; m_prev = 0; m_pend = 0;
    m_rise = 0; m_ovr = 0; m_run = 0;
  endtask

  // one clock edge of the model, using the inputs now applied
  task automatic model_step();
    bit seen;
    bit qe;
    seen = hist[0];
    qe = (m_lvl != m_prev) && (m_lvl ? irq_en_rise : irq_en_fall);
    if (m_pend) begin
      if (evt_ack) begin
        m_ovr = 0;
        if (qe) m_rise = m_lvl;
        else m_pend = 0;
      end else if (qe) begin
        m_ovr = 1;
      end
    end else if (qe) begin
      m_pend = 1;
      m_rise = m_lvl;
    end
    m_prev = m_lvl;
    if (seen == m_lvl) m_run = 0;
    else if (m_run >= int'(deb_limit)) begin
      m_lvl = seen;
      m_run = 0;
    end else m_run++;
    void'(hist.pop_front());
    hist.push_back(gpio_in);
  endtask

  initial begin
    int hold;
    // rise with limit 3: level after 6 edges, event one later
    do_reset();
    deb_limit = 3;
    irq_en_rise = 1'b1;
    gpio_in = 1'b1;
    tick(5);
    chk("l3_level_e5", gpio_level, 0);
    tick(1);
    chk("l3_level_e6", gpio_level, 1);
    chk("l3_valid_e6", evt_valid, 0);
    tick(1);
    chk("l3_valid_e7", evt_valid, 1);
    chk("l3_rise_e7", evt_rise, 1);

    // short glitch is filtered
    do_reset();
    deb_limit = 4;
    irq_en_rise = 1'b1;
    irq_en_fall = 1'b1;
    gpio_in = 1'b1;
    tick(3);
    gpio_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_level", gpio_level, 0);
      chk("glitch_valid", evt_valid, 0);
    end

    // two edges without ack -> overrun, then ack clears
    do_reset();
    irq_en_rise = 1'b1;
    irq_en_fall = 1'b1;
    gpio_in = 1'b1;
    tick(4);
    chk("ovr_valid1", evt_valid, 1);
    gpio_in = 1'b0;
    tick(4);
    chk("ovr_valid", evt_valid, 1);
    chk("ovr_rise", evt_rise, 1);
    chk("ovr_flag", evt_overrun, 1);
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    chk("ovr_ack_valid", evt_valid, 0);
    chk("ovr_ack_flag", evt_overrun, 0);

    // ack coinciding with a new falling edge
    do_reset();
    irq_en_rise = 1'b1;
    irq_en_fall = 1'b1;
    gpio_in = 1'b1;
    tick(4);
    chk("reload_valid0", evt_valid, 1);
    gpio_in = 1'b0;
    tick(3);
    chk("reload_level", gpio_level, 0);
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    chk("reload_valid", evt_valid, 1);
    chk("reload_rise", evt_rise, 0);
    chk("reload_ovr", evt_overrun, 0);

    // limit lowered from 10 to 2 with counter at 5
    do_reset();
    deb_limit = 10;
    gpio_in = 1'b1;
    tick(7);
    chk("lim_level_c5", gpio_level, 0);
    deb_limit = 2;
    tick(1);
    chk("lim_level_new", gpio_level, 1);

    // reset mid-count with an event pending
    do_reset();
    irq_en_rise = 1'b1;
    gpio_in = 1'b1;
    tick(4);
    chk("mid_valid", evt_valid, 1);
    deb_limit = 4;
    gpio_in = 1'b0;
    tick(4);
    chk("mid_level", gpio_level, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_level", gpio_level, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_rise", evt_rise, 0);
    chk("mid_rst_ovr", evt_overrun, 0);
    tick(2);
    resetn = 1'b1;
    tick(20);
    chk("post_rst_level", gpio_level, 0);
    chk("post_rst_valid", evt_valid, 0);

    // random traffic against the model
    do_reset();
    model_reset();
    hold = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) deb_limit = DW'($urandom_range(0, 6));
      if (c % 37 == 0) begin
        irq_en_rise = 1'($urandom);
        irq_en_fall = 1'($urandom);
      end
      hold--;
      if (hold <= 0) begin
        gpio_in = ~gpio_in;
        hold = $urandom_range(1, 12);
      end
      evt_ack = ($urandom_range(0, 9) < 3);
      model_step();
      tick(1);
      chk("rnd_level", gpio_level, int'(m_lvl));
      chk("rnd_valid", evt_valid, int'(m_pend));
      chk("rnd_rise", evt_rise, int'(m_rise));
      chk("rnd_ovr", evt_overrun, int'(m_ovr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_input_monitor.md
GPIO_INPUT_MONITOR -- requirements
Module: gpio_input_monitor

Interface
REQ-001 SHALL have parameter DEB_W, default 8, giving the debounce counter and limit width in bits.
REQ-002 SHALL have port core_clk, input, 1, the single block clock.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports vccd1 and vssd1, inout, 1 each, present only under USE_POWER_PINS.
REQ-005 SHALL have port gpio_in, input, 1, asynchronous pad input.
REQ-006 SHALL have port deb_limit, input, DEB_W, the number of extra stable cycles required before accepting a level change.
REQ-007 SHALL have ports irq_en_rise and irq_en_fall, input, 1 each, which enable event capture per edge type.
REQ-008 SHALL have port gpio_level, output, 1, the debounced pad level.
REQ-009 SHALL have port evt_valid, output, 1, which flags a pending edge event.
REQ-010 SHALL have port evt_rise, output, 1, the pending event type: 1 = rising, 0 = falling.
REQ-011 SHALL have port evt_ack, input, 1, the consumer acknowledge.
REQ-012 SHALL have port evt_overrun, output, 1, a sticky lost-event flag.

Function
REQ-013 SHALL pass gpio_in through a two-flop synchronizer; the second flop output is sync_in.
REQ-014 SHALL hold a DEB_W-bit counter cleared whenever sync_in equals gpio_level.
REQ-015 SHALL increment the counter each cycle sync_in differs from gpio_level and the counter is below deb_limit.
REQ-016 SHALL load gpio_level with sync_in and clear the counter when sync_in differs and counter >= deb_limit (>= covers deb_limit lowered mid-count).
REQ-017 SHALL give a latency of deb_limit+3 core_clk edges from the first edge sampling a changed gpio_in to a changed gpio_level, provided gpio_in stays stable.
REQ-018 SHALL discard any glitch shorter than the debounce window, clearing the counter with no level change.
REQ-019 SHALL implement an event FSM with two states: IDLE (evt_valid=0) and PENDING (evt_valid=1).
REQ-020 SHALL define a qualified edge as a gpio_level change with the matching irq_en_rise or irq_en_fall high in that same cycle.
REQ-021 In IDLE, a qualified edge SHALL move the FSM to PENDING on the next edge, with evt_rise = the new level.
REQ-022 In PENDING, evt_ack high with no qualified edge SHALL return the FSM to IDLE.
REQ-023 In PENDING, evt_ack high together with a qualified edge SHALL keep PENDING, reload evt_rise and set no overrun.
REQ-024 In PENDING, a qualified edge without evt_ack SHALL keep evt_rise unchanged and set evt_overrun.
REQ-025 evt_overrun SHALL clear only on a cycle with evt_valid=1 and evt_ack=1, unless REQ-024 sets it in that same cycle.
REQ-026 SHALL ignore evt_ack while in IDLE.
REQ-027 Disabling an enable SHALL NOT clear an already pending event.

Reset
REQ-028 On resetn low, synchronizer flops, counter, gpio_level, evt_valid, evt_rise and evt_overrun SHALL clear to 0 asynchronously.
REQ-029 Reset asserted mid-count or mid-event SHALL discard all state, with no event generated on release.
REQ-030 After reset release with gpio_in=1, gpio_level SHALL rise after deb_limit+3 edges and produce a rising event only if irq_en_rise=1.

Structure
REQ-031 Package gpio_mon_pkg SHALL hold the DEB_W default, the FSM state typedef (IDLE, PENDING) and the event type constants EVT_FALL=0 and EVT_RISE=1.
REQ-032 The synchronizer SHALL be sub-module gpio_sync2 (2 flops, async active-low reset, reset value 0), instantiated once.
REQ-033 All sequential logic SHALL be in the core_clk domain; no combinational path SHALL run from gpio_in to any output.

Verification
REQ-034 deb_limit=3, gpio_in 0->1 held -> gpio_level=1 exactly 6 edges later; with irq_en_rise=1, evt_valid=1 and evt_rise=1 one edge after that.
REQ-035 deb_limit=4, gpio_in high 3 cycles then low -> gpio_level stays 0 and evt_valid stays 0.
REQ-036 Both enables=1, two debounced edges with no ack -> evt_rise=1 retained and evt_overrun=1; ack -> evt_valid=0, evt_overrun=0.
REQ-037 Ack in the same cycle as a new qualified falling edge -> evt_valid stays 1, evt_rise=0, evt_overrun=0.
REQ-038 deb_limit changed from 10 to 2 while the counter is at 5 -> gpio_level updates on the next cycle.
REQ-039 resetn pulsed low while the counter is at 2 and an event is pending -> all outputs 0 immediately; no event follows if gpio_in=0.
